// File: rtl/avg_bram_seq_if.sv
// Sequencer bus for avg_bram_seq: upstream flow control on one side and
// lsu BRAM read/write control plus frame status on the other.
// The slave modport is the sequencer. The master modport is whatever
// drives the datapath and consumes the BRAM control.
interface avg_bram_seq_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  stall;
    logic                  clear;
    logic                  in_valid;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  mix_en;
    logic                  frame_done;
    logic [7:0]            frame_count;

    modport master (
        output stall, clear, in_valid,
        input  rd_en, rd_addr, wr_en, wr_addr, mix_en, frame_done, frame_count
    );

    modport slave (
        input  stall, clear, in_valid,
        output rd_en, rd_addr, wr_en, wr_addr, mix_en, frame_done, frame_count
    );
endinterface

// File: rtl/avg_bram_seq.sv
// avg_bram_seq: address/enable sequencer for the frame-averaging lsu BRAM.
// Each accepted word issues a read of the previous average at its index.
// The matching write-back is issued DEPTH (read + combine latency)
// non-stalled cycles later, from a small shift pipeline.
// mix_en tells the datapath whether the BRAM data is real history (SET)
// or whether this is the first frame (UNSET, pass-through).
// Optional build macro AVG_BRAM_SEQ_FRAME_CNT_EN adds a saturating 8-bit
// completed-frame counter. Without it, frame_count is tied to zero.
module avg_bram_seq #(
    parameter int IMAGE_DIM  = 512,
    parameter int PIX_WIDTH  = 8,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LAT     = 1,
    parameter int PIPE_LAT   = 1
) (
    input  logic          clk,
    input  logic          aresetn,
    avg_bram_seq_if.slave bus
);

    localparam int WORDS = IMAGE_DIM * IMAGE_DIM * PIX_WIDTH / DATA_WIDTH;
    localparam int DEPTH = RD_LAT + PIPE_LAT;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    typedef enum logic {
        UNSET = 1'b0,   // first frame, BRAM holds no history
        SET   = 1'b1    // one full frame written, history valid
    } state_t;

    // One in-flight write-back: valid bit, mix tag and target index
    typedef struct packed {
        logic                  vld;
        logic                  tag;
        logic [ADDR_WIDTH-1:0] addr;
    } seq_ent_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    seq_ent_t [DEPTH-1:0]    pipe;
    seq_ent_t                push_ent;
    seq_ent_t                wr_ent;

    logic acc;
    logic at_last;

    // Accept only when nothing is freezing or restarting the sequence
    always_comb begin
        acc     = bus.in_valid & ~bus.stall & ~bus.clear;
        at_last = (rd_ptr == LAST_ADDR);
    end

    // Entry pushed each advancing cycle; a bubble when nothing was accepted
    always_comb begin
        push_ent      = '0;
        push_ent.vld  = acc;
        push_ent.tag  = acc & (state == SET);
        push_ent.addr = rd_ptr;
    end

    // Read pointer and first-frame/averaging mode; SET is sticky until clear
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= UNSET;
            rd_ptr <= '0;
        end else if (bus.clear) begin
            state  <= UNSET;
            rd_ptr <= '0;
        end else if (acc) begin
            if (at_last) begin
                // Wrap explicitly so non-power-of-2 WORDS never overruns
                rd_ptr <= '0;
                state  <= SET;
            end else begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Write-back delay line: shifts on every non-stalled cycle, flushed by clear
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pipe <= '0;
        end else if (bus.clear) begin
            pipe <= '0;
        end else if (!bus.stall) begin
            pipe[0] <= push_ent;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign wr_ent = pipe[DEPTH-1];

    // Read side: history is only fetched once a full frame exists
    always_comb begin
        bus.rd_en   = acc & (state == SET);
        bus.rd_addr = rd_ptr;
    end

    // Write side: the oldest pipeline entry; stall and clear suppress the strobe
    always_comb begin
        bus.wr_en      = wr_ent.vld & ~bus.stall & ~bus.clear;
        bus.wr_addr    = wr_ent.addr;
        bus.mix_en     = wr_ent.tag & wr_ent.vld;
        bus.frame_done = bus.wr_en & (wr_ent.addr == LAST_ADDR);
    end

`ifdef AVG_BRAM_SEQ_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    // Completed-frame counter, saturating at 255 so it never wraps
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
        end else if (bus.clear) begin
            frame_cnt <= '0;
        end else if (bus.frame_done && (frame_cnt != 8'hFF)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign bus.frame_count = frame_cnt;
`else
    assign bus.frame_count = 8'd0;
`endif

endmodule
